collect_2x1_one_hot_pipe: RTL
=============================

COLLECT_2X1_ONE_HOT_PIPE -- requirements
Module: collect_2x1_one_hot_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of one data word.
REQ-002 Parameter IN_COMMAND_WIDTH, default 2, SHALL set the width of the per-input destination tag.
REQ-003 Derived parameter OUT_COMMAND_WIDTH SHALL equal IN_COMMAND_WIDTH+1 and SHALL be the width of the output tag.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 i_en  input  1  SHALL be the collect switch enable.
REQ-007 i_valid  input  2  SHALL carry per-input valid, with bit 1 = node side and bit 0 = bus side.
REQ-008 i_data_bus  input  2*DATA_WIDTH  SHALL be {node word, bus word}, with the node word in [2*DATA_WIDTH-1:DATA_WIDTH].
REQ-009 i_cmd  input  2*IN_COMMAND_WIDTH  SHALL be {node tag, bus tag}, with the node tag in the upper half.
REQ-010 o_ready  output  2  SHALL carry per-input ready, with the same bit order as i_valid.
REQ-011 o_valid  output  1  SHALL indicate that the registered output word is valid.
REQ-012 o_data_bus  output  DATA_WIDTH  SHALL carry the registered merged word.
REQ-013 o_cmd  output  OUT_COMMAND_WIDTH  SHALL carry the registered tag {source bit, input tag}.
REQ-014 i_ready  input  1  SHALL be the downstream ready.

Function
REQ-015 An input transfer on side k SHALL occur when i_valid[k] and o_ready[k] are both 1 in the same cycle, and an output transfer SHALL occur when o_valid and i_ready are both 1 in the same cycle.
REQ-016 can_accept SHALL equal (!o_valid | i_ready).
REQ-017 o_ready[k] SHALL equal i_en & can_accept & grant[k], combinationally.
REQ-018 At most one o_ready bit SHALL be 1 in any cycle.
REQ-019 grant SHALL be 2'b00 when i_valid is 2'b00.
REQ-020 grant SHALL select the sole valid side when exactly one i_valid bit is 1.
REQ-021 When i_valid is 2'b11, grant SHALL select the side named by the 1-bit round-robin pointer prio (0 = bus, 1 = node).
REQ-022 After an input transfer from side k, prio SHALL become ~k.
REQ-023 When no input transfer occurs, prio SHALL hold its value.
REQ-024 On an input transfer from side k, the next o_data_bus SHALL be that side's word, with 1-cycle latency from acceptance to o_valid.
REQ-025 On an input transfer, the next o_cmd SHALL be {k, that side's tag}, with the source bit as MSB so a downstream one-hot distribute stage can strip it.
REQ-026 On an input transfer, the next o_valid SHALL be 1.
REQ-027 An output transfer without a simultaneous input transfer SHALL clear o_valid to 0 and zero o_data_bus and o_cmd.
REQ-028 On a simultaneous output transfer and input transfer, the new word SHALL replace the old word with no bubble, sustaining full throughput.
REQ-029 While o_valid=1 and i_ready=0, o_data_bus, o_cmd and o_valid SHALL hold their values (stall), and o_ready SHALL be 2'b00.
REQ-030 When i_en=0, no input SHALL be accepted (o_ready=2'b00), a held output word SHALL still drain normally, and prio SHALL hold.
REQ-031 Whenever o_valid=0, o_data_bus and o_cmd SHALL be all-zero (dummy data).
REQ-032 An input word SHALL never be duplicated, dropped or reordered within its own side.

Reset
REQ-033 When rst=1 at a rising clk edge, o_valid, o_data_bus and o_cmd SHALL be set to 0 and prio SHALL be set to 0 (bus side first).
REQ-034 While rst=1, o_ready SHALL be 2'b00.
REQ-035 A held output word SHALL be discarded when rst is asserted while o_valid=1 (reset mid-transfer).
REQ-036 The first input transfer SHALL be possible in the cycle after rst deasserts.

Verification
REQ-037 Reset, then i_en=1, i_valid=2'b01, bus word 0xA5, bus tag 2'b10, i_ready=1 -> o_ready=2'b01; next cycle o_valid=1, o_data_bus=0xA5, o_cmd=3'b010.
REQ-038 i_valid=2'b11 held with node words N0,N1 and bus words B0,B1, i_ready=1 -> output order B0,N0,B1,N1, with one word per cycle, no bubbles, and o_cmd MSB alternating 0,1,0,1.
REQ-039 Output holding a word with i_ready=0 for 3 cycles, i_valid=2'b10 -> o_ready=2'b00 for those cycles and the output word stable; when i_ready rises, the node word is accepted in that same cycle and presented the next cycle.
REQ-040 i_en=0 with o_valid=1 and i_ready=1 -> the held word drains, o_valid=0 next cycle, no input accepted, and prio unchanged.
REQ-041 rst pulsed for 1 cycle while o_valid=1 and i_ready=0 -> o_valid=0, o_data_bus=0 and prio=0 after the edge, and a subsequent contested grant goes to the bus side.
REQ-042 Random valid/ready stress over 10k cycles -> a scoreboard matches each side's words in order, with no duplicates and at most one o_ready bit set.

Source files
------------

// File: rtl/collect_2x1_one_hot_pipe.sv
// 2:1 collect switch with round-robin arbitration and a single registered
// output slot. The winning side's tag is extended with a source bit (MSB)
// so a downstream one-hot distribute stage can route the reply back.
module collect_2x1_one_hot_pipe #(
  parameter  int DATA_WIDTH        = 32,
  parameter  int IN_COMMAND_WIDTH  = 2,
  localparam int OUT_COMMAND_WIDTH = IN_COMMAND_WIDTH + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_en,
  input  logic [1:0]                    i_valid,
  input  logic [2*DATA_WIDTH-1:0]       i_data_bus,
  input  logic [2*IN_COMMAND_WIDTH-1:0] i_cmd,
  output logic [1:0]                    o_ready,
  output logic                          o_valid,
  output logic [DATA_WIDTH-1:0]         o_data_bus,
  output logic [OUT_COMMAND_WIDTH-1:0]  o_cmd,
  input  logic                          i_ready
);

  logic                        prio;
  logic                        can_accept;
  logic [1:0]                  grant;
  logic [1:0]                  acc;
  logic                        src;
  logic [DATA_WIDTH-1:0]       sel_data;
  logic [IN_COMMAND_WIDTH-1:0] sel_cmd;

  // Round-robin grant: sole requester wins, contention resolved by prio.
  always_comb begin
    grant = 2'b00;
    case (i_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Handshake and source-word selection for the granted side.
  always_comb begin
    can_accept = ~o_valid | i_ready;
    o_ready    = (i_en & can_accept & ~rst) ? grant : 2'b00;
    acc        = o_ready & i_valid;
    src        = acc[1];
    sel_data   = src ? i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH]
                     : i_data_bus[DATA_WIDTH-1:0];
    sel_cmd    = src ? i_cmd[2*IN_COMMAND_WIDTH-1:IN_COMMAND_WIDTH]
                     : i_cmd[IN_COMMAND_WIDTH-1:0];
  end

  // Output slot: load on accept, zero on drain, otherwise hold; prio flips
  // away from the side just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      o_cmd      <= '0;
      prio       <= 1'b0;
    end else if (|acc) begin
      o_valid    <= 1'b1;
      o_data_bus <= sel_data;
      o_cmd      <= {src, sel_cmd};
      prio       <= ~src;
    end else if (o_valid & i_ready) begin
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      o_cmd      <= '0;
    end
  end

endmodule
